ysyx_23060240_csr_ctrl: RTL and testbench

//   Initiator side of the CSR-file port: sequences CSR instructions and traps for the EXU.

---
 rtl/ysyx_23060240_csr_pkg.sv | 35 +++
 rtl/ysyx_23060240_csr_alu.sv | 21 ++
 rtl/ysyx_23060240_csr_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_ysyx_23060240_csr_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060240_csr_pkg.sv
// Shared encodings for the CSR-port controller: request opcodes, CSR addresses
// and the sequencing FSM states.
package ysyx_23060240_csr_pkg;

   localparam logic [31:0] MCAUSE_ECALL = 32'd11;

   typedef enum logic [2:0] {
      OP_CSRRW = 3'd0,
      OP_CSRRS = 3'd1,
      OP_CSRRC = 3'd2,
      OP_ECALL = 3'd3,
      OP_MRET  = 3'd4
   } csr_op_e;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_ECALL = 3'd3,
      S_MRET  = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   // Only the four machine-mode CSRs the file implements are accepted.
   function automatic logic csr_addr_ok(input logic [11:0] addr);
      return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
             (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
   endfunction

endpackage

// File: rtl/ysyx_23060240_csr_alu.sv
// Write-data function for CSR read-modify-write: RW passes src, RS sets, RC clears.
module ysyx_23060240_csr_alu
   import ysyx_23060240_csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] src,
   output logic [XLEN-1:0] wdata
);

   always_comb begin
      case (op)
         OP_CSRRS: wdata = old_val | src;
         OP_CSRRC: wdata = old_val & ~src;
         default:  wdata = src;
      endcase
   end

endmodule

// File: rtl/ysyx_23060240_csr_ctrl.sv
// Initiator side of the CSR-file port: sequences one CSR instruction or trap at a
// time and returns the rd writeback / PC redirect with a single done pulse.
module ysyx_23060240_csr_ctrl
   import ysyx_23060240_csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [11:0]     req_addr,
   input  logic [XLEN-1:0] req_src,
   input  logic            req_src_zero,
   input  logic [4:0]      req_rd,
   input  logic [XLEN-1:0] req_pc,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] w_csr_data,
   output logic            w_csr_en,
   output logic            r_csr_en,
   output logic            jump_ecall,
   output logic            jump_mret,
   output logic [XLEN-1:0] csr_pc,
   input  logic [XLEN-1:0] r_csr_data,
   output logic            done,
   output logic            rd_we,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] rd_wdata,
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_pc,
   output logic            illegal
);

   state_e          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [11:0]     addr_q, addr_d;
   logic [XLEN-1:0] src_q, src_d;
   logic            src_zero_q, src_zero_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] old_q, old_d;

   logic            req_ready_q, req_ready_d;
   logic [11:0]     csr_addr_q, csr_addr_d;
   logic [XLEN-1:0] w_csr_data_q, w_csr_data_d;
   logic            w_csr_en_q, w_csr_en_d;
   logic            r_csr_en_q, r_csr_en_d;
   logic            jump_ecall_q, jump_ecall_d;
   logic            jump_mret_q, jump_mret_d;
   logic [XLEN-1:0] csr_pc_q, csr_pc_d;
   logic            done_q, done_d;
   logic            rd_we_q, rd_we_d;
   logic [4:0]      rd_addr_q, rd_addr_d;
   logic [XLEN-1:0] rd_wdata_q, rd_wdata_d;
   logic            redir_valid_q, redir_valid_d;
   logic [XLEN-1:0] redir_pc_q, redir_pc_d;
   logic            illegal_q, illegal_d;

   logic [XLEN-1:0] alu_wdata;
   logic            accept;
   logic            is_csr_op;
   logic            req_legal;

   ysyx_23060240_csr_alu #(.XLEN(XLEN)) u_alu (
      .op      (op_q),
      .old_val (r_csr_data),
      .src     (src_q),
      .wdata   (alu_wdata)
   );

   assign accept    = req_valid && req_ready_q;
   assign is_csr_op = (req_op == OP_CSRRW) || (req_op == OP_CSRRS) || (req_op == OP_CSRRC);
   assign req_legal = is_csr_op ? csr_addr_ok(req_addr)
                                : ((req_op == OP_ECALL) || (req_op == OP_MRET));

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      addr_d        = addr_q;
      src_d         = src_q;
      src_zero_d    = src_zero_q;
      rd_d          = rd_q;
      old_d         = old_q;
      req_ready_d   = 1'b0;
      csr_addr_d    = '0;
      w_csr_data_d  = '0;
      w_csr_en_d    = 1'b0;
      r_csr_en_d    = 1'b0;
      jump_ecall_d  = 1'b0;
      jump_mret_d   = 1'b0;
      csr_pc_d      = '0;
      done_d        = 1'b0;
      rd_we_d       = 1'b0;
      rd_addr_d     = '0;
      rd_wdata_d    = '0;
      redir_valid_d = 1'b0;
      redir_pc_d    = '0;
      illegal_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready_d = 1'b1;
            if (accept) begin
               req_ready_d = 1'b0;
               op_d        = req_op;
               addr_d      = req_addr;
               src_d       = req_src;
               src_zero_d  = req_src_zero;
               rd_d        = req_rd;
               if (!req_legal) begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  illegal_d = 1'b1;
               end else if (is_csr_op) begin
                  state_d    = S_READ;
                  csr_addr_d = req_addr;
                  r_csr_en_d = 1'b1;
               end else if (req_op == OP_ECALL) begin
                  state_d      = S_ECALL;
                  jump_ecall_d = 1'b1;
                  csr_pc_d     = req_pc;
               end else begin
                  state_d     = S_MRET;
                  jump_mret_d = 1'b1;
               end
            end
         end
         S_READ: begin
            old_d = r_csr_data;
            // Set/clear with a zero operand must leave the CSR untouched.
            if ((op_q != OP_CSRRW) && src_zero_q) begin
               state_d    = S_DONE;
               done_d     = 1'b1;
               rd_we_d    = (rd_q != 5'd0);
               rd_addr_d  = rd_q;
               rd_wdata_d = r_csr_data;
            end else begin
               state_d      = S_WRITE;
               csr_addr_d   = addr_q;
               w_csr_en_d   = 1'b1;
               w_csr_data_d = alu_wdata;
            end
         end
         S_WRITE: begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            rd_we_d    = (rd_q != 5'd0);
            rd_addr_d  = rd_q;
            rd_wdata_d = old_q;
         end
         S_ECALL, S_MRET: begin
            state_d       = S_DONE;
            done_d        = 1'b1;
            redir_valid_d = 1'b1;
            redir_pc_d    = r_csr_data;
         end
         S_DONE: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         op_q          <= '0;
         addr_q        <= '0;
         src_q         <= '0;
         src_zero_q    <= 1'b0;
         rd_q          <= '0;
         old_q         <= '0;
         req_ready_q   <= 1'b1;
         csr_addr_q    <= '0;
         w_csr_data_q  <= '0;
         w_csr_en_q    <= 1'b0;
         r_csr_en_q    <= 1'b0;
         jump_ecall_q  <= 1'b0;
         jump_mret_q   <= 1'b0;
         csr_pc_q      <= '0;
         done_q        <= 1'b0;
         rd_we_q       <= 1'b0;
         rd_addr_q     <= '0;
         rd_wdata_q    <= '0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         illegal_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         src_q         <= src_d;
         src_zero_q    <= src_zero_d;
         rd_q          <= rd_d;
         old_q         <= old_d;
         req_ready_q   <= req_ready_d;
         csr_addr_q    <= csr_addr_d;
         w_csr_data_q  <= w_csr_data_d;
         w_csr_en_q    <= w_csr_en_d;
         r_csr_en_q    <= r_csr_en_d;
         jump_ecall_q  <= jump_ecall_d;
         jump_mret_q   <= jump_mret_d;
         csr_pc_q      <= csr_pc_d;
         done_q        <= done_d;
         rd_we_q       <= rd_we_d;
         rd_addr_q     <= rd_addr_d;
         rd_wdata_q    <= rd_wdata_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
         illegal_q     <= illegal_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign csr_addr    = csr_addr_q;
   assign w_csr_data  = w_csr_data_q;
   assign w_csr_en    = w_csr_en_q;
   assign r_csr_en    = r_csr_en_q;
   assign jump_ecall  = jump_ecall_q;
   assign jump_mret   = jump_mret_q;
   assign csr_pc      = csr_pc_q;
   assign done        = done_q;
   assign rd_we       = rd_we_q;
   assign rd_addr     = rd_addr_q;
   assign rd_wdata    = rd_wdata_q;
   assign redir_valid = redir_valid_q;
   assign redir_pc    = redir_pc_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_ysyx_23060240_csr_ctrl.sv
// Directed bench: controller paired with a small behavioural CSR file; expected
// results are queued at issue time and popped when done pulses.
module tb_ysyx_23060240_csr_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [11:0] req_addr;
   logic [31:0] req_src;
   logic        req_src_zero;
   logic [4:0]  req_rd;
   logic [31:0] req_pc;
   logic [11:0] csr_addr;
   logic [31:0] w_csr_data;
   logic        w_csr_en, r_csr_en, jump_ecall, jump_mret;
   logic [31:0] csr_pc;
   logic [31:0] r_csr_data;
   logic        done, rd_we, redir_valid, illegal;
   logic [4:0]  rd_addr;
   logic [31:0] rd_wdata, redir_pc;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ysyx_23060240_csr_ctrl #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_src(req_src), .req_src_zero(req_src_zero),
      .req_rd(req_rd), .req_pc(req_pc),
      .csr_addr(csr_addr), .w_csr_data(w_csr_data), .w_csr_en(w_csr_en),
      .r_csr_en(r_csr_en), .jump_ecall(jump_ecall), .jump_mret(jump_mret),
      .csr_pc(csr_pc), .r_csr_data(r_csr_data),
      .done(done), .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
      .redir_valid(redir_valid), .redir_pc(redir_pc), .illegal(illegal)
   );

   // Behavioural CSR file: combinational read, negedge write, trap side effects.
   logic [31:0] mstatus = 32'h0, mtvec = 32'h0, mepc = 32'h0, mcause = 32'h0;

   always_comb begin
      r_csr_data = 32'h0;
      if (jump_ecall) r_csr_data = mtvec;
      else if (jump_mret) r_csr_data = mepc;
      else if (r_csr_en) begin
         case (csr_addr)
            12'h300: r_csr_data = mstatus;
            12'h305: r_csr_data = mtvec;
            12'h341: r_csr_data = mepc;
            12'h342: r_csr_data = mcause;
            default: r_csr_data = 32'h0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (w_csr_en) begin
         case (csr_addr)
            12'h300: mstatus = w_csr_data;
            12'h305: mtvec   = w_csr_data;
            12'h341: mepc    = w_csr_data;
            12'h342: mcause  = w_csr_data;
            default: ;
         endcase
      end
      if (jump_ecall) begin
         mepc   = csr_pc;
         mcause = 32'd11;
      end
   end

   // Strobe monitor.
   int          w_cnt = 0, strobe_cnt = 0, excl_err = 0;
   logic [31:0] last_wdata = 32'h0;
   logic [11:0] last_waddr = 12'h0;

   always @(negedge clk) begin
      if (w_csr_en) begin
         w_cnt++;
         last_wdata = w_csr_data;
         last_waddr = csr_addr;
      end
      if (w_csr_en || r_csr_en || jump_ecall || jump_mret) strobe_cnt++;
      if ((w_csr_en && r_csr_en) || ((jump_ecall || jump_mret) && (w_csr_en || r_csr_en)) ||
          (jump_ecall && jump_mret))
         excl_err++;
   end

   typedef struct {
      logic        rd_we;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic        redir_valid;
      logic [31:0] redir_pc;
      logic        illegal;
      int          lat;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input string tag, input logic [2:0] op, input logic [11:0] addr,
                        input logic [31:0] src, input logic sz, input logic [4:0] rd,
                        input logic [31:0] pc, input exp_t e, input int exp_w,
                        input int exp_strobes, input logic [31:0] exp_wdata);
      int   lat;
      int   w0, s0;
      exp_t g;
      @(negedge clk); #1;
      chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
      w0 = w_cnt;
      s0 = strobe_cnt;
      req_valid = 1'b1; req_op = op; req_addr = addr; req_src = src;
      req_src_zero = sz; req_rd = rd; req_pc = pc;
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0; req_op = 3'd0; req_addr = 12'h0; req_src = 32'hDEAD_BEEF;
      req_src_zero = 1'b0; req_rd = 5'd31; req_pc = 32'h0;
      lat = 0;
      while (lat < 10) begin
         @(negedge clk); #1;
         lat++;
         if (lat == 1) chk({tag, ".busy"}, {31'd0, req_ready}, 32'd0);
         if (done) break;
      end
      g = sb.pop_front();
      chk({tag, ".latency"}, lat, g.lat);
      chk({tag, ".rd_we"}, {31'd0, rd_we}, {31'd0, g.rd_we});
      chk({tag, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, g.rd_addr});
      chk({tag, ".rd_wdata"}, rd_wdata, g.rd_wdata);
      chk({tag, ".redir_valid"}, {31'd0, redir_valid}, {31'd0, g.redir_valid});
      chk({tag, ".redir_pc"}, redir_pc, g.redir_pc);
      chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, g.illegal});
      @(negedge clk); #1;
      chk({tag, ".done_once"}, {31'd0, done}, 32'd0);
      chk({tag, ".ready_after"}, {31'd0, req_ready}, 32'd1);
      chk({tag, ".w_count"}, w_cnt - w0, exp_w);
      chk({tag, ".strobes"}, strobe_cnt - s0, exp_strobes);
      if (exp_w != 0) begin
         chk({tag, ".w_data"}, last_wdata, exp_wdata);
         chk({tag, ".w_addr"}, {20'd0, last_waddr}, {20'd0, addr});
      end
      $display("txn %-10s op=%0d addr=%h lat=%0d rd_wdata=%h redir_pc=%h illegal=%0b",
               tag, op, addr, lat, rd_wdata, redir_pc, illegal);
   endtask

   function automatic exp_t e_csr(input logic [4:0] rd, input logic [31:0] old, input int lat);
      exp_t e;
      e.rd_we = (rd != 5'd0); e.rd_addr = rd; e.rd_wdata = old;
      e.redir_valid = 1'b0; e.redir_pc = 32'h0; e.illegal = 1'b0; e.lat = lat;
      return e;
   endfunction

   function automatic exp_t e_trap(input logic [31:0] target);
      exp_t e;
      e.rd_we = 1'b0; e.rd_addr = 5'd0; e.rd_wdata = 32'h0;
      e.redir_valid = 1'b1; e.redir_pc = target; e.illegal = 1'b0; e.lat = 2;
      return e;
   endfunction

   function automatic exp_t e_ill();
      exp_t e;
      e.rd_we = 1'b0; e.rd_addr = 5'd0; e.rd_wdata = 32'h0;
      e.redir_valid = 1'b0; e.redir_pc = 32'h0; e.illegal = 1'b1; e.lat = 1;
      return e;
   endfunction

   initial begin
      int seen_done;
      rst_n = 1'b1;
      req_valid = 1'b0; req_op = 3'd0; req_addr = 12'h0; req_src = 32'h0;
      req_src_zero = 1'b0; req_rd = 5'd0; req_pc = 32'h0;
      #2 rst_n = 1'b0;
      @(negedge clk); #1;
      chk("reset.ready", {31'd0, req_ready}, 32'd1);
      chk("reset.done", {31'd0, done}, 32'd0);
      chk("reset.strobes", {28'd0, w_csr_en, r_csr_en, jump_ecall, jump_mret}, 32'd0);
      chk("reset.redir", {31'd0, redir_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      issue("rw_mtvec", 3'd0, 12'h305, 32'h8000_0100, 1'b0, 5'd5, 32'h0,
            e_csr(5'd5, 32'h0, 3), 1, 2, 32'h8000_0100);
      chk("mtvec_val", mtvec, 32'h8000_0100);
      issue("rw_mepc", 3'd0, 12'h341, 32'h0000_1234, 1'b0, 5'd0, 32'h0,
            e_csr(5'd0, 32'h0, 3), 1, 2, 32'h0000_1234);
      issue("rs_mepc", 3'd1, 12'h341, 32'h0000_00F0, 1'b0, 5'd3, 32'h0,
            e_csr(5'd3, 32'h1234, 3), 1, 2, 32'h0000_12F4);
      issue("rc_mepc", 3'd2, 12'h341, 32'h0000_0004, 1'b0, 5'd3, 32'h0,
            e_csr(5'd3, 32'h12F4, 3), 1, 2, 32'h0000_12F0);
      chk("mepc_val", mepc, 32'h0000_12F0);
      issue("rw_mcause", 3'd0, 12'h342, 32'h0000_000B, 1'b0, 5'd0, 32'h0,
            e_csr(5'd0, 32'h0, 3), 1, 2, 32'h0000_000B);
      issue("rs_skip", 3'd1, 12'h342, 32'h0, 1'b1, 5'd7, 32'h0,
            e_csr(5'd7, 32'hB, 2), 0, 1, 32'h0);
      issue("rc_skip", 3'd2, 12'h341, 32'h0, 1'b1, 5'd9, 32'h0,
            e_csr(5'd9, 32'h12F0, 2), 0, 1, 32'h0);
      issue("rw_mstatus", 3'd0, 12'h300, 32'h0000_1888, 1'b0, 5'd1, 32'h0,
            e_csr(5'd1, 32'h0, 3), 1, 2, 32'h0000_1888);

      issue("ecall", 3'd3, 12'h000, 32'h0, 1'b0, 5'd0, 32'h8000_0040,
            e_trap(32'h8000_0100), 0, 1, 32'h0);
      chk("ecall_mepc", mepc, 32'h8000_0040);
      chk("ecall_mcause", mcause, 32'd11);
      issue("mret", 3'd4, 12'h000, 32'h0, 1'b0, 5'd0, 32'h0,
            e_trap(32'h8000_0040), 0, 1, 32'h0);

      issue("ill_addr", 3'd0, 12'h7C0, 32'h5555_5555, 1'b0, 5'd4, 32'h0,
            e_ill(), 0, 0, 32'h0);
      issue("ill_op6", 3'd6, 12'h305, 32'h5555_5555, 1'b0, 5'd4, 32'h0,
            e_ill(), 0, 0, 32'h0);
      issue("ill_op5", 3'd5, 12'h300, 32'h0, 1'b0, 5'd2, 32'h0,
            e_ill(), 0, 0, 32'h0);
      chk("mtvec_kept", mtvec, 32'h8000_0100);

      // Reset while the WRITE strobe is up.
      @(negedge clk); #1;
      req_valid = 1'b1; req_op = 3'd0; req_addr = 12'h300; req_src = 32'hA5A5_0000;
      req_src_zero = 1'b0; req_rd = 5'd6;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("rst_mid.in_write", {31'd0, w_csr_en}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid.strobes", {28'd0, w_csr_en, r_csr_en, jump_ecall, jump_mret}, 32'd0);
      chk("rst_mid.outs", {29'd0, done, redir_valid, rd_we}, 32'd0);
      chk("rst_mid.ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         if (done || redir_valid) seen_done++;
      end
      chk("rst_mid.no_done", seen_done, 32'd0);
      chk("rst_mid.ready_after", {31'd0, req_ready}, 32'd1);
      $display("txn rst_mid    reset during WRITE, done pulses after release=%0d", seen_done);

      chk("mutual_exclusion", excl_err, 32'd0);
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
